aes_round_engine: RTL and testbench

Iterative AES-128 encryption engine that reuses one or more unrolled round-step instances over a registered state and an on-the-fly key schedule. It is the parametrised successor to the single combinational round used today. ROUNDS_PER_CYCLE sets the area/latency trade-off. The engine sits behind the core's AES accelerator register interface, with valid/ready handshakes on both input and output.

---
 rtl/aes_eng_pkg.sv | 43 ++++
 rtl/aes_round_step.sv | 62 ++++++
 rtl/aes_round_engine.sv | 108 ++++++++++
 tb/tb_aes_round_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_eng_pkg.sv
// Shared AES-128 definitions for the iterative round engine: S-box, Rcon,
// GF(2^8) doubling, block type and engine FSM states.
package aes_eng_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} eng_state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Entry x sits at bits [2047-8x -: 8], i.e. row-major from the top.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd10) ? RCON[r] : 8'h00;
  endfunction

  function automatic logic [7:0] byte_at(input aes_blk_t b, input int unsigned k);
    return b[127 - 8*k -: 8];
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// One combinational AES-128 encryption round plus the matching key-schedule
// step; the engine chains several of these per clock.
module aes_round_step
  import aes_eng_pkg::*;
(
  input  aes_blk_t    state_i,
  input  aes_blk_t    key_i,
  input  logic [3:0]  rnd_i,
  input  logic        last_i,
  output aes_blk_t    state_o,
  output aes_blk_t    key_o
);

  aes_blk_t    sb, sr, mc;
  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] tmp;

  always_comb begin
    sb      = '0;
    sr      = '0;
    mc      = '0;
    a0      = '0;
    a1      = '0;
    a2      = '0;
    a3      = '0;
    tmp     = '0;
    key_o   = '0;
    state_o = '0;

    for (int unsigned i = 0; i < 16; i++) begin
      sb[127 - 8*i -: 8] = sbox(byte_at(state_i, i));
    end

    // Column-major state: byte r+4c moves left by r columns.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[127 - 8*(4*c + r) -: 8] = byte_at(sb, 4*((c + r) % 4) + r);
      end
    end

    for (int unsigned c = 0; c < 4; c++) begin
      a0 = byte_at(sr, 4*c);
      a1 = byte_at(sr, 4*c + 1);
      a2 = byte_at(sr, 4*c + 2);
      a3 = byte_at(sr, 4*c + 3);
      mc[127 - 8*(4*c)     -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[127 - 8*(4*c + 1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[127 - 8*(4*c + 3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    tmp = {sbox(key_i[23:16]), sbox(key_i[15:8]), sbox(key_i[7:0]), sbox(key_i[31:24])}
        ^ {rcon(rnd_i), 24'h000000};
    key_o[127:96] = key_i[127:96] ^ tmp;
    key_o[95:64]  = key_i[95:64]  ^ key_o[127:96];
    key_o[63:32]  = key_i[63:32]  ^ key_o[95:64];
    key_o[31:0]   = key_i[31:0]   ^ key_o[63:32];

    state_o = (last_i ? sr : mc) ^ key_o;
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine, ROUNDS_PER_CYCLE rounds per clock.
// Define AES_ROUND_ENGINE_BLK_CNT_EN to add the blk_cnt handshake counter.
module aes_round_engine
  import aes_eng_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
  output logic [31:0]  blk_cnt,
`endif
  output logic         busy
);

  localparam int unsigned NUM_ROUNDS = 10;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  eng_state_e st_q, st_d;
  aes_blk_t   state_q, state_d, key_q, key_d;
  logic [3:0] rnd_q, rnd_d;
  logic       accept;

  aes_blk_t chain_s [ROUNDS_PER_CYCLE+1];
  aes_blk_t chain_k [ROUNDS_PER_CYCLE+1];

  assign chain_s[0] = state_q;
  assign chain_k[0] = key_q;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_step
    logic [3:0] rnd;
    assign rnd = rnd_q + 4'(g);
    aes_round_step u_step (
      .state_i (chain_s[g]),
      .key_i   (chain_k[g]),
      .rnd_i   (rnd),
      .last_i  (rnd == 4'(NUM_ROUNDS)),
      .state_o (chain_s[g+1]),
      .key_o   (chain_k[g+1])
    );
  end

  assign in_ready  = ~rst & ((st_q == IDLE) | ((st_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q != IDLE);
  assign out_data  = state_q;

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (st_q)
      RUN: begin
        state_d = chain_s[ROUNDS_PER_CYCLE];
        key_d   = chain_k[ROUNDS_PER_CYCLE];
        rnd_d   = rnd_q + 4'(ROUNDS_PER_CYCLE);
        if (rnd_d > 4'(NUM_ROUNDS)) st_d = DONE;
      end
      DONE:    if (out_ready) st_d = IDLE;
      IDLE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
    // Acceptance from IDLE or from DONE overrides the plain transitions above.
    if (accept) begin
      state_d = in_data ^ in_key;
      key_d   = in_key;
      rnd_d   = 4'd1;
      st_d    = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
  logic [31:0] blk_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        blk_cnt_q <= '0;
    else if (out_valid & out_ready) blk_cnt_q <= blk_cnt_q + 32'd1;
  end
  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine at ROUNDS_PER_CYCLE = 1, 2, 5 and 10
// using the FIPS-197 example vectors.
module tb_aes_round_engine;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data, in_key;
  logic         iv   [4];
  logic         ordy [4];
  logic         ir   [4];
  logic         ov   [4];
  logic         bsy  [4];
  logic [127:0] od   [4];
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
  logic [31:0]  bc   [4];
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes_round_engine #(
      .ROUNDS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (od[g]),
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
      .blk_cnt   (bc[g]),
`endif
      .busy      (bsy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair, wait (bounded) for in_ready, then pass the accepting edge
  // and scramble the inputs to show they are no longer sampled.
  task automatic offer(input int d, input logic [127:0] pt, input logic [127:0] key);
    int waited = 0;
    in_data = pt;
    in_key  = key;
    iv[d]   = 1'b1;
    while (!ir[d] && waited < 100) begin
      tick();
      waited++;
    end
    check("accept_ready", 128'(ir[d]), 128'd1);
    tick();
    iv[d]   = 1'b0;
    in_data = ~pt;
    in_key  = ~key;
  endtask

  // Called just after the accepting edge; counts cycles until out_valid.
  task automatic wait_out(input int d, input string tag, input logic [127:0] exp_ct,
                          input int exp_lat);
    int lat = 1;
    while (!ov[d] && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check({tag, "_ct"}, od[d], exp_ct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    in_data = '0;
    in_key  = '0;
    for (int i = 0; i < 4; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    tick();
    tick();
    check("rst_in_ready", 128'(ir[0]), 128'd0);
    check("rst_out_valid", 128'(ov[0]), 128'd0);
    check("rst_busy", 128'(bsy[0]), 128'd0);
    check("rst_out_data", od[0], 128'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 128'(ir[0]), 128'd1);

    // FIPS-197 C.1 at one round per cycle.
    offer(0, C1_PT, C1_KEY);
    wait_out(0, "c1_r1", C1_CT, 11);
    tick();
    check("c1_r1_done_ov", 128'(ov[0]), 128'd0);
    check("c1_r1_idle_busy", 128'(bsy[0]), 128'd0);

    // FIPS-197 Appendix B at 2, 5 and 10 rounds per cycle.
    for (int d = 1; d < 4; d++) begin
      offer(d, B_PT, B_KEY);
      wait_out(d, $sformatf("appb_d%0d", d), B_CT, (d == 1) ? 6 : (d == 2) ? 3 : 2);
      tick();
      check($sformatf("appb_d%0d_ov_clr", d), 128'(ov[d]), 128'd0);
    end

    // Backpressure: hold out_ready low for 20 cycles with a competing offer.
    ordy[0] = 1'b0;
    offer(0, B_PT, B_KEY);
    wait_out(0, "bp", B_CT, 11);
    in_data = C1_PT;
    in_key  = C1_KEY;
    iv[0]   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_data_stable", od[0], B_CT);
      check("bp_in_ready", 128'(ir[0]), 128'd0);
      check("bp_out_valid", 128'(ov[0]), 128'd1);
    end
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
    check("bp_cnt_stalled", 128'(bc[0]), 128'd1);
`endif
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    tick();
    check("bp_release_ov", 128'(ov[0]), 128'd0);
    check("bp_release_busy", 128'(bsy[0]), 128'd0);
    check("bp_release_ready", 128'(ir[0]), 128'd1);
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
    check("bp_cnt_released", 128'(bc[0]), 128'd2);
`endif

    // Back-to-back: in_valid held, second pair taken in the DONE cycle.
    in_data = C1_PT;
    in_key  = C1_KEY;
    iv[0]   = 1'b1;
    tick();
    in_data = B_PT;
    in_key  = B_KEY;
    wait_out(0, "b2b_first", C1_CT, 11);
    check("b2b_ready_in_done", 128'(ir[0]), 128'd1);
    tick();
    iv[0]   = 1'b0;
    in_data = '0;
    in_key  = '0;
    check("b2b_ov_drop", 128'(ov[0]), 128'd0);
    check("b2b_busy", 128'(bsy[0]), 128'd1);
    wait_out(0, "b2b_second", B_CT, 11);
    tick();
    check("b2b_idle", 128'(bsy[0]), 128'd0);

    // Reset while round 4 is in flight.
    offer(0, C1_PT, C1_KEY);
    tick();
    tick();
    tick();
    check("mid_busy", 128'(bsy[0]), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_ov", 128'(ov[0]), 128'd0);
    check("abort_busy", 128'(bsy[0]), 128'd0);
    check("abort_data", od[0], 128'd0);
    check("abort_ready", 128'(ir[0]), 128'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 128'(ir[0]), 128'd1);
    check("post_rst_ov", 128'(ov[0]), 128'd0);
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
    check("cnt_after_rst", 128'(bc[0]), 128'd0);
`endif
    offer(0, C1_PT, C1_KEY);
    wait_out(0, "c1_after_rst", C1_CT, 11);
    tick();
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
    check("cnt_one", 128'(bc[0]), 128'd1);
`endif
    ordy[0] = 1'b0;
    offer(0, B_PT, B_KEY);
    wait_out(0, "stall2", B_CT, 11);
    for (int i = 0; i < 5; i++) tick();
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
    check("cnt_stall2", 128'(bc[0]), 128'd1);
`endif
    ordy[0] = 1'b1;
    tick();
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
    check("cnt_two", 128'(bc[0]), 128'd2);
`endif
    offer(0, C1_PT, C1_KEY);
    wait_out(0, "third", C1_CT, 11);
    tick();
`ifdef AES_ROUND_ENGINE_BLK_CNT_EN
    check("cnt_three", 128'(bc[0]), 128'd3);
`endif
    check("final_idle", 128'(bsy[0]), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
